// File: rtl/sky130_fd_io__lvclamp_ctrl_if.sv
// LV clamp controller bus: detector/test inputs and clamp gate outputs.
// master drives the event side, slave is the controller.
interface sky130_fd_io__lvclamp_ctrl_if #(
  parameter int NCH    = 4,
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 8
);
  logic [NCH-1:0]       trig;
  logic [NCH-1:0]       mask;
  logic [NCH-1:0]       force_en;
  logic [HOLD_W-1:0]    hold_len;
  logic                 clr_cnt;
  logic [NCH-1:0]       clamp_en;
  logic [NCH-1:0]       cooling;
  logic                 any_active;
  logic [NCH*CNT_W-1:0] evt_cnt;

  modport master (
    output trig, mask, force_en, hold_len, clr_cnt,
    input  clamp_en, cooling, any_active, evt_cnt
  );

  modport slave (
    input  trig, mask, force_en, hold_len, clr_cnt,
    output clamp_en, cooling, any_active, evt_cnt
  );
endinterface

// File: rtl/sky130_fd_io__lvclamp_ctrl.sv
// Multi-channel LV ESD clamp controller: debounce, hold with
// retrigger, cool-down and saturating per-channel event counters.
module sky130_fd_io__lvclamp_ctrl #(
  parameter int NCH      = 4,
  parameter int DEB_CYC  = 3,
  parameter int HOLD_W   = 8,
  parameter int COOL_CYC = 4,
  parameter int CNT_W    = 8
) (
  input logic clk,
  input logic rst_n,
  sky130_fd_io__lvclamp_ctrl_if.slave bus
);
  localparam int QW = $clog2(DEB_CYC);
  localparam int CW = $clog2(COOL_CYC + 1);
  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [QW-1:0] Q_LAST = QW'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] H_ONE = HOLD_W'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LOAD = CW'(COOL_CYC);
  localparam logic [CNT_W-1:0] N_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUAL,
    S_HOLD,
    S_COOL
  } st_t;

  logic [HOLD_W-1:0] h_load;
  logic [NCH-1:0]    nxt_hold;
  logic [NCH-1:0]    nxt_cool;
  logic [NCH-1:0]    clamp_n;
  logic [NCH-1:0]    clamp_q;
  logic [NCH-1:0]    cool_q;
  logic              any_q;

  // a zero hold length still gives a one-cycle clamp
  assign h_load = (bus.hold_len == '0) ? H_ONE : bus.hold_len;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    st_t               st;
    st_t               st_n;
    logic [QW-1:0]     q;
    logic [QW-1:0]     q_n;
    logic [HOLD_W-1:0] h;
    logic [HOLD_W-1:0] h_n;
    logic [CW-1:0]     c;
    logic [CW-1:0]     c_n;
    logic [CNT_W-1:0]  cnt;
    logic              go;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st <= S_IDLE;
        q  <= '0;
        h  <= '0;
        c  <= '0;
      end else begin
        st <= st_n;
        q  <= q_n;
        h  <= h_n;
        c  <= c_n;
      end
    end

    always_comb begin
      st_n = st;
      q_n  = q;
      h_n  = h;
      c_n  = c;
      go   = 1'b0;
      unique case (st)
        S_IDLE: begin
          if (bus.trig[i] && !bus.mask[i]) begin
            st_n = S_QUAL;
            q_n  = Q_ONE;
          end
        end
        S_QUAL: begin
          if (!bus.trig[i] || bus.mask[i]) begin
            st_n = S_IDLE;
            q_n  = '0;
          end else if (q == Q_LAST) begin
            st_n = S_HOLD;
            h_n  = h_load;
            q_n  = '0;
            go   = 1'b1;
          end else begin
            q_n = q + Q_ONE;
          end
        end
        S_HOLD: begin
          if (bus.trig[i]) begin
            h_n = h_load;
          end else if (h == H_ONE) begin
            st_n = S_COOL;
            c_n  = C_LOAD;
          end else begin
            h_n = h - H_ONE;
          end
        end
        S_COOL: begin
          if (c == C_ONE) begin
            st_n = S_IDLE;
          end else begin
            c_n = c - C_ONE;
          end
        end
        default: st_n = S_IDLE;
      endcase
    end

    // a clear on the same edge as an event keeps that event
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (bus.clr_cnt) begin
        cnt <= go ? N_ONE : '0;
      end else if (go && cnt != '1) begin
        cnt <= cnt + N_ONE;
      end
    end

    assign nxt_hold[i] = (st_n == S_HOLD);
    assign nxt_cool[i] = (st_n == S_COOL);
    assign bus.evt_cnt[i*CNT_W +: CNT_W] = cnt;
  end

  assign clamp_n = nxt_hold | bus.force_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clamp_q <= '0;
      cool_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      clamp_q <= clamp_n;
      cool_q  <= nxt_cool;
      any_q   <= |clamp_n;
    end
  end

  assign bus.clamp_en   = clamp_q;
  assign bus.cooling    = cool_q;
  assign bus.any_active = any_q;
endmodule

// File: tb/tb_sky130_fd_io__lvclamp_ctrl.sv
// Bench for the LV clamp controller: timer-based reference model
// checked every cycle, plus directed literal expectations.
module tb_sky130_fd_io__lvclamp_ctrl;
  localparam int NCH  = 4;
  localparam int DEB  = 3;
  localparam int HW   = 8;
  localparam int COOL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NCH-1:0] trig = '0;
  logic [NCH-1:0] mask = '0;
  logic [NCH-1:0] force_en = '0;
  logic [HW-1:0]  hold_len = 8'd5;
  logic           clr_cnt = 1'b0;

  always #5 clk = ~clk;

  sky130_fd_io__lvclamp_ctrl_if #(.NCH(NCH), .HOLD_W(HW), .CNT_W(8)) b8 ();
  sky130_fd_io__lvclamp_ctrl_if #(.NCH(NCH), .HOLD_W(HW), .CNT_W(2)) b2 ();

  assign b8.trig     = trig;
  assign b8.mask     = mask;
  assign b8.force_en = force_en;
  assign b8.hold_len = hold_len;
  assign b8.clr_cnt  = clr_cnt;
  assign b2.trig     = trig;
  assign b2.mask     = mask;
  assign b2.force_en = force_en;
  assign b2.hold_len = hold_len;
  assign b2.clr_cnt  = clr_cnt;

  sky130_fd_io__lvclamp_ctrl #(
    .NCH(NCH), .DEB_CYC(DEB), .HOLD_W(HW),
    .COOL_CYC(COOL), .CNT_W(8)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b8)
  );

  sky130_fd_io__lvclamp_ctrl #(
    .NCH(NCH), .DEB_CYC(DEB), .HOLD_W(HW),
    .COOL_CYC(COOL), .CNT_W(2)
  ) u_sat (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int hi_clamp[NCH];
  int hi_cool[NCH];

  int streak[NCH];
  int hold_l[NCH];
  int cool_l[NCH];
  int cnt[NCH];
  logic [NCH-1:0] e_clamp;
  logic [NCH-1:0] e_cool;
  logic           e_any;
  logic [31:0]    e8;
  logic [7:0]     e2;
  bit             mdl_ok = 1'b0;

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // timers count remaining hold/cool cycles; streak counts trig run
  always @(posedge clk) begin
    int h;
    bit ev;
    h = (hold_len == 0) ? 1 : int'(hold_len);
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        streak[i] = 0;
        hold_l[i] = 0;
        cool_l[i] = 0;
        cnt[i]    = 0;
      end
      e_clamp = '0;
      e_cool  = '0;
      mdl_ok  = 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ev = 1'b0;
        if (cool_l[i] > 0) begin
          cool_l[i]--;
        end else if (hold_l[i] > 0) begin
          if (trig[i]) hold_l[i] = h;
          else if (hold_l[i] == 1) begin
            hold_l[i] = 0;
            cool_l[i] = COOL;
          end else hold_l[i]--;
        end else if (trig[i] && !mask[i]) begin
          streak[i]++;
          if (streak[i] == DEB) begin
            streak[i] = 0;
            hold_l[i] = h;
            ev = 1'b1;
          end
        end else begin
          streak[i] = 0;
        end
        if (clr_cnt) cnt[i] = ev ? 1 : 0;
        else if (ev) cnt[i]++;
        e_clamp[i] = (hold_l[i] > 0) | force_en[i];
        e_cool[i]  = cool_l[i] > 0;
      end
    end
    e_any = |e_clamp;
    for (int i = 0; i < NCH; i++) begin
      e8[i*8 +: 8] = 8'(mn(cnt[i], 255));
      e2[i*2 +: 2] = 2'(mn(cnt[i], 3));
    end
    #2;
    if (mdl_ok) begin
      check("clamp_en", 32'(b8.clamp_en), 32'(e_clamp));
      check("cooling", 32'(b8.cooling), 32'(e_cool));
      check("any_active", 32'(b8.any_active), 32'(e_any));
      check("evt_cnt8", b8.evt_cnt, e8);
      check("clamp_en_w2", 32'(b2.clamp_en), 32'(e_clamp));
      check("evt_cnt2", 32'(b2.evt_cnt), 32'(e2));
      for (int i = 0; i < NCH; i++) begin
        hi_clamp[i] += int'(b8.clamp_en[i]);
        hi_cool[i]  += int'(b8.cooling[i]);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_hi();
    for (int i = 0; i < NCH; i++) begin
      hi_clamp[i] = 0;
      hi_cool[i]  = 0;
    end
  endtask

  initial begin
    clr_hi();
    wait_n(2);
    rst_n = 1'b1;
    check("rst_clamp", 32'(b8.clamp_en), 32'h0);
    check("rst_cool", 32'(b8.cooling), 32'h0);
    check("rst_any", 32'(b8.any_active), 32'h0);
    check("rst_cnt", b8.evt_cnt, 32'h0);
    clr_hi();
    wait_n(10);
    check("idle_clamp", 32'(hi_clamp[0] + hi_clamp[1] +
          hi_clamp[2] + hi_clamp[3]), 32'd0);

    hold_len = 8'd5;
    clr_hi();
    trig[0] = 1'b1;
    wait_n(2);
    check("qual_edge2", 32'(b8.clamp_en[0]), 32'd0);
    wait_n(1);
    check("qual_edge3", 32'(b8.clamp_en[0]), 32'd1);
    trig[0] = 1'b0;
    wait_n(14);
    check("basic_hold", 32'(hi_clamp[0]), 32'd5);
    check("basic_cool", 32'(hi_cool[0]), 32'd4);
    check("basic_cnt", 32'(b8.evt_cnt[7:0]), 32'd1);
    check("basic_other", 32'(hi_clamp[1] + hi_clamp[2] +
          hi_clamp[3]), 32'd0);

    clr_hi();
    trig[1] = 1'b1;
    wait_n(2);
    trig[1] = 1'b0;
    wait_n(1);
    trig[1] = 1'b1;
    wait_n(2);
    trig[1] = 1'b0;
    wait_n(5);
    check("glitch_clamp", 32'(hi_clamp[1]), 32'd0);
    check("glitch_cnt", 32'(b8.evt_cnt[15:8]), 32'd0);

    hold_len = 8'd4;
    clr_hi();
    trig[0] = 1'b1;
    wait_n(3);
    trig[0] = 1'b0;
    wait_n(2);
    trig[0] = 1'b1;
    wait_n(1);
    trig[0] = 1'b0;
    wait_n(15);
    check("retrig_hold", 32'(hi_clamp[0]), 32'd7);
    check("retrig_cnt", 32'(b8.evt_cnt[7:0]), 32'd2);

    hold_len = 8'd5;
    clr_hi();
    mask[2] = 1'b1;
    trig[2] = 1'b1;
    wait_n(10);
    trig[2] = 1'b0;
    check("mask_clamp", 32'(hi_clamp[2]), 32'd0);
    check("mask_cnt", 32'(b8.evt_cnt[23:16]), 32'd0);
    mask[2] = 1'b0;
    wait_n(1);
    trig[2] = 1'b1;
    wait_n(3);
    trig[2] = 1'b0;
    mask[2] = 1'b1;
    wait_n(12);
    mask[2] = 1'b0;
    check("mask_mid_hold", 32'(hi_clamp[2]), 32'd5);
    check("mask_mid_cnt", 32'(b8.evt_cnt[23:16]), 32'd1);

    clr_hi();
    force_en[3] = 1'b1;
    check("force_pre", 32'(b8.clamp_en[3]), 32'd0);
    wait_n(1);
    check("force_clamp", 32'(b8.clamp_en[3]), 32'd1);
    check("force_any", 32'(b8.any_active), 32'd1);
    wait_n(2);
    force_en[3] = 1'b0;
    wait_n(1);
    check("force_off", 32'(b8.clamp_en[3]), 32'd0);
    check("force_cnt", 32'(b8.evt_cnt[31:24]), 32'd0);
    check("force_cool", 32'(hi_cool[3]), 32'd0);

    hold_len = 8'd1;
    for (int k = 0; k < 5; k++) begin
      trig[1] = 1'b1;
      wait_n(3);
      trig[1] = 1'b0;
      wait_n(7);
    end
    check("sat_w2", 32'(b2.evt_cnt[3:2]), 32'd3);
    check("sat_w8", 32'(b8.evt_cnt[15:8]), 32'd5);
    trig[1] = 1'b1;
    wait_n(2);
    clr_cnt = 1'b1;
    wait_n(1);
    clr_cnt = 1'b0;
    trig[1] = 1'b0;
    check("clr_hit_w2", 32'(b2.evt_cnt), 32'h04);
    check("clr_hit_w8", b8.evt_cnt, 32'h0000_0100);
    wait_n(8);

    hold_len = 8'd5;
    trig[0] = 1'b1;
    wait_n(3);
    trig[0] = 1'b0;
    wait_n(2);
    check("hold_pre_rst", 32'(b8.clamp_en[0]), 32'd1);
    rst_n = 1'b0;
    wait_n(1);
    check("rst_mid_clamp", 32'(b8.clamp_en), 32'h0);
    check("rst_mid_any", 32'(b8.any_active), 32'h0);
    check("rst_mid_cnt", 32'(b2.evt_cnt), 32'h0);
    rst_n = 1'b1;
    trig[0] = 1'b1;
    wait_n(2);
    check("rst_requal2", 32'(b8.clamp_en[0]), 32'd0);
    wait_n(1);
    check("rst_requal3", 32'(b8.clamp_en[0]), 32'd1);
    trig[0] = 1'b0;
    wait_n(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
